// File: rtl/p_ctrl_pkg.sv
// p_ctrl_pkg -- shared types and constants for the p_ctrl serial frame receiver.
// Holds the receiver state enum, default field widths, the broadcast address
// and small elaboration-time helpers for sizing the bit counter.
package p_ctrl_pkg;

  // Receiver phases: waiting for a start bit, then one state per frame field
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    OP   = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OP_W   = 3;
  localparam int DEF_DATA_W = 62;

  // All-ones address, only meaningful when broadcast reception is compiled in
  localparam logic [DEF_ADDR_W-1:0] BCAST_ADDR = 8'hFF;

  // Largest of three field widths, used to size the shared bit counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter width able to index 0 .. n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/p_ctrl_shreg.sv
// p_ctrl_shreg -- serial-in, parallel-out shift register with enable.
// Bits enter at the LSB so a field sent MSB first ends up in natural order.
module p_ctrl_shreg
  import p_ctrl_pkg::*;
#(
  parameter int W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  generate
    if (W == 1) begin : g_single
      // A one-bit field simply captures the incoming bit
      always_ff @(posedge clk) begin
        if (nRst) begin
          q <= '0;
        end else if (en) begin
          q <= din;
        end
      end
    end else begin : g_multi
      // Shift left by one, new bit into the LSB, while the field is active
      always_ff @(posedge clk) begin
        if (nRst) begin
          q <= '0;
        end else if (en) begin
          q <= {q[W-2:0], din};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/p_ctrl.sv
// p_ctrl -- fixed-length serial frame receiver with address filtering.
// Frame: start bit 0, address, opcode, data, each field MSB first, one bit per
// clk. When the address matches, the opcode is presented for one cycle on the
// edge that samples the last data bit.
// Optional build macro: P_CTRL_BROADCAST_EN -- also accept the all-ones address.
module p_ctrl
  import p_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode
);

  localparam int CNT_W = cnt_width(max3(ADDR_W, OP_W, DATA_W));

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   data_q;
  logic                addr_en;
  logic                op_en;
  logic                data_en;
  logic                field_done;
  logic                accept;
  logic                unused_data;

  // Route rx into whichever field register the current phase is filling
  always_comb begin
    addr_en    = 1'b0;
    op_en      = 1'b0;
    data_en    = 1'b0;
    field_done = 1'b0;
    case (state)
      ADDR: begin
        addr_en    = 1'b1;
        field_done = (cnt == ADDR_LAST);
      end
      OP: begin
        op_en      = 1'b1;
        field_done = (cnt == OP_LAST);
      end
      DATA: begin
        data_en    = 1'b1;
        field_done = (cnt == DATA_LAST);
      end
      default: begin
        field_done = 1'b0;
      end
    endcase
  end

  // Decide whether the frame now ending is addressed to this node
  always_comb begin
    accept = (addr_q == address);
`ifdef P_CTRL_BROADCAST_EN
    if (addr_q == ADDR_W'(BCAST_ADDR)) begin
      accept = 1'b1;
    end
`endif
  end

  p_ctrl_shreg #(.W(ADDR_W)) u_addr (
    .clk  (clk),
    .nRst (nRst),
    .en   (addr_en),
    .din  (rx),
    .q    (addr_q)
  );

  p_ctrl_shreg #(.W(OP_W)) u_op (
    .clk  (clk),
    .nRst (nRst),
    .en   (op_en),
    .din  (rx),
    .q    (op_q)
  );

  p_ctrl_shreg #(.W(DATA_W)) u_data (
    .clk  (clk),
    .nRst (nRst),
    .en   (data_en),
    .din  (rx),
    .q    (data_q)
  );

  // The payload is kept on-chip only; nothing downstream consumes it yet
  assign unused_data = ^data_q;

  // Frame sequencing, bit counting and the one-cycle opcode pulse
  always_ff @(posedge clk) begin
    if (nRst) begin
      state  <= IDLE;
      cnt    <= '0;
      opcode <= '0;
    end else begin
      opcode <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (field_done) begin
            cnt   <= '0;
            state <= OP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OP: begin
          if (field_done) begin
            cnt   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (field_done) begin
            cnt   <= '0;
            state <= IDLE;
            if (accept) begin
              opcode <= op_q;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p_ctrl.sv
// tb_p_ctrl -- self-checking bench for p_ctrl: directed scenarios plus
// randomized frames compared cycle by cycle against a frame-level model.
module tb_p_ctrl;

  localparam int AW = 8;
  localparam int OW = 3;
  localparam int DW = 62;
  localparam int FL = AW + OW + DW;

  logic          clk = 1'b0;
  logic          nRst;
  logic [AW-1:0] address;
  logic          rx;
  logic [OW-1:0] opcode;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulseCnt       = 0;
  int lastPulseCycle = -1;
  int lastPulseVal   = 0;

  bit            inFrame = 1'b0;
  bit            fbits[$];
  logic [OW-1:0] expOp = '0;
  bit            bcastEn;

  always #5 clk = ~clk;

  p_ctrl #(.ADDR_W(AW), .OP_W(OW), .DATA_W(DW)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .address (address),
    .rx      (rx),
    .opcode  (opcode)
  );

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame-level reference: collect bits after a start bit, decode when complete
  task automatic modelStep(input bit r, input bit rs);
    int a;
    int o;
    if (rs) begin
      inFrame = 1'b0;
      fbits.delete();
      expOp = '0;
    end else begin
      expOp = '0;
      if (!inFrame) begin
        if (!r) begin
          inFrame = 1'b1;
          fbits.delete();
        end
      end else begin
        fbits.push_back(r);
        if (fbits.size() == FL) begin
          a = 0;
          o = 0;
          for (int i = 0; i < AW; i++) a = a * 2 + int'(fbits[i]);
          for (int i = 0; i < OW; i++) o = o * 2 + int'(fbits[AW + i]);
          if (a == int'(address) || (bcastEn && a == 255)) expOp = OW'(o);
          inFrame = 1'b0;
          fbits.delete();
        end
      end
    end
  endtask

  // Drive one clock's worth of inputs, advance the model, check the output
  task automatic applyStimulus(input bit r, input bit rs);
    rx   = r;
    nRst = rs;
    @(posedge clk);
    cyc++;
    modelStep(r, rs);
    @(negedge clk);
    checkOutput("opcode", {61'd0, opcode}, {61'd0, expOp});
    if (opcode !== '0) begin
      pulseCnt++;
      lastPulseCycle = cyc;
      lastPulseVal   = int'(opcode);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
  endtask

  // Send a whole frame; startCyc is the cycle number of the start-bit edge
  task automatic sendFrame(input logic [AW-1:0] a, input logic [OW-1:0] o,
                           input logic [DW-1:0] d, output int startCyc);
    logic [FL:0] f;
    f = {1'b0, a, o, d};
    startCyc = cyc + 1;
    for (int i = FL; i >= 0; i--) applyStimulus(f[i], 1'b0);
  endtask

  // Send the first n bits of a frame, then hold reset for one cycle
  task automatic sendAborted(input logic [AW-1:0] a, input logic [OW-1:0] o,
                             input logic [DW-1:0] d, input int n);
    logic [FL:0] f;
    f = {1'b0, a, o, d};
    for (int i = FL; i > FL - n; i--) applyStimulus(f[i], 1'b0);
    applyStimulus(f[FL - n], 1'b1);
  endtask

  initial begin
    int s;
    int p1;
    int gap;
    int sel;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

`ifdef P_CTRL_BROADCAST_EN
    bcastEn = 1'b1;
`else
    bcastEn = 1'b0;
`endif

    rx      = 1'b1;
    nRst    = 1'b1;
    address = 8'hAA;
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("reset_opcode", {61'd0, opcode}, 64'd0);

    // Nominal accepted frame after long idle
    idle(500);
    pulseCnt = 0;
    sendFrame(8'hAA, 3'h4, 62'd100, s);
    idle(5);
    checkOutput("match_pulses", pulseCnt, 1);
    checkOutput("match_value", lastPulseVal, 4);
    checkOutput("match_latency", lastPulseCycle - s, 73);

    // Foreign address consumes the whole frame, then a frame follows directly
    pulseCnt = 0;
    sendFrame(8'h55, 3'h4, 62'd100, s);
    checkOutput("nomatch_pulses", pulseCnt, 0);
    sendFrame(8'hAA, 3'h1, 62'h3FFF_FFFF_FFFF_FFFF, s);
    checkOutput("after_nomatch_value", lastPulseVal, 1);
    checkOutput("after_nomatch_latency", lastPulseCycle - s, 73);

    // Back-to-back frames
    idle(3);
    pulseCnt = 0;
    sendFrame(8'hAA, 3'h3, 62'd0, s);
    p1 = lastPulseCycle;
    checkOutput("b2b_first", lastPulseVal, 3);
    sendFrame(8'hAA, 3'h5, 62'd1, s);
    idle(3);
    checkOutput("b2b_second", lastPulseVal, 5);
    checkOutput("b2b_gap", lastPulseCycle - p1, 74);
    checkOutput("b2b_pulses", pulseCnt, 2);

    // Reset during the data field aborts the frame
    pulseCnt = 0;
    sendAborted(8'hAA, 3'h4, 62'd100, 1 + AW + OW + 20);
    idle(80);
    checkOutput("abort_pulses", pulseCnt, 0);
    sendFrame(8'hAA, 3'h6, 62'd0, s);
    idle(2);
    checkOutput("abort_next_value", lastPulseVal, 6);
    checkOutput("abort_next_pulses", pulseCnt, 1);

    // Opcode zero is invisible
    pulseCnt = 0;
    sendFrame(8'hAA, 3'h0, 62'd5, s);
    idle(2);
    checkOutput("op0_pulses", pulseCnt, 0);

    // All-ones address
    pulseCnt = 0;
    sendFrame(8'hFF, 3'h2, 62'd7, s);
    idle(2);
    checkOutput("bcast_pulses", pulseCnt, bcastEn ? 1 : 0);

    // Long idle line
    applyStimulus(1'b1, 1'b1);
    pulseCnt = 0;
    idle(10000);
    checkOutput("long_idle_pulses", pulseCnt, 0);
    sendFrame(8'hAA, 3'h7, 62'd9, s);
    checkOutput("long_idle_then_frame", lastPulseCycle - s, 73);

    // Randomized frames, gaps, address changes and occasional aborts
    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 3));
      ra  = (sel == 0) ? address : (sel == 1) ? 8'hFF : (sel == 2) ? 8'hAA : AW'($urandom);
      rd  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) begin
        sendAborted(ra, OW'($urandom), rd, int'($urandom_range(1, FL)));
        idle(FL + 2);
      end else begin
        sendFrame(ra, OW'($urandom), rd, s);
      end
      gap = int'($urandom_range(0, 5));
      if (gap > 0 && $urandom_range(0, 4) == 0) address = AW'($urandom);
      idle(gap);
    end

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
